clk_int_div_multi: RTL and testbench

//  NUM_CH-channel runtime-programmable integer clock divider from one source clock.

---
 rtl/clk_int_div_multi.sv | 185 ++++++++++++++++++
 tb/tb_clk_int_div_multi.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/clk_int_div_multi.sv
// ---------------------------------------------------------------------------
// clk_int_div_multi
//   NUM_CH independent, runtime-programmable integer clock dividers running
//   off a single source clock. Each channel divides by N = div+1 (N >= 2).
//   A new ratio is taken through a valid/ready handshake and only applied at
//   a period boundary, so the divided clock never produces a runt pulse.
//   div_done_o flags that the current ratio has been active for DONE_DELAY
//   full output periods.
//
// Ports
//   clk_i        source clock (only clock)
//   rst_n_i      synchronous active-low reset
//   en_i         [NUM_CH]          per-channel run enable
//   div_i        [NUM_CH*W]        ratio fields, channel k at [k*W +: W]
//   div_valid_i  [NUM_CH]          ratio update request
//   div_ready_o  [NUM_CH]          update accepted when valid & ready
//   div_done_o   [NUM_CH]          ratio active for DONE_DELAY periods
//   clk_trg_o    [NUM_CH]          1-cycle pulse, the cycle before clk_o rises
//   clk_o        [NUM_CH]          divided clocks
//
// Build option
//   CLK_INT_DIV_ODD_DUTY50_EN  when defined, odd ratios get a 50% duty cycle
//   by ORing a half-cycle (negedge) delayed copy of the high phase into
//   clk_o. When undefined, only posedge logic exists and odd N is high for
//   floor(N/2) cycles.
// ---------------------------------------------------------------------------

module clk_int_div_ch #(
    parameter int W          = 16,
    parameter int DONE_DELAY = 3,
    parameter int DIV_RST    = 1
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         en_i,
    input  logic [W-1:0] div_i,
    input  logic         div_valid_i,
    output logic         div_ready_o,
    output logic         div_done_o,
    output logic         clk_trg_o,
    output logic         clk_o
);

    localparam int DW = (DONE_DELAY < 1) ? 1 : $clog2(DONE_DELAY + 1);

    typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_DRAIN} st_e;

    st_e           st_q, st_d;
    logic [W-1:0]  cnt_q, cnt_d;
    logic [W-1:0]  cur_q, cur_d;
    logic [W-1:0]  pend_q, pend_d;
    logic          pend_vld_q, pend_vld_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          clk_q, trg_q, done_q;
    logic          running, prd_end;

    // High phase length floor(N/2), one bit wider so cur = all-ones is safe.
    function automatic logic [W:0] hi_of(input logic [W-1:0] c);
        return ({1'b0, c} + (W+1)'(1)) >> 1;
    endfunction

    always_comb begin
        st_d       = st_q;
        cnt_d      = cnt_q;
        cur_d      = cur_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        dcnt_d     = dcnt_q;
        running    = (st_q != ST_STOP);
        prd_end    = running && (cnt_q == cur_q);

        if (running)
            cnt_d = prd_end ? '0 : cnt_q + W'(1);

        // Saturating count of completed periods under the current ratio.
        if (prd_end && (dcnt_q != DW'(DONE_DELAY)))
            dcnt_d = dcnt_q + DW'(1);

        // Apply only at a period boundary (or immediately when stopped) and
        // restart the period so the new ratio begins with a full high phase.
        if (pend_vld_q && (prd_end || !running)) begin
            cur_d      = pend_q;
            pend_vld_d = 1'b0;
            dcnt_d     = '0;
            cnt_d      = '0;
        end

        // Handshake and apply are mutually exclusive: apply needs pend_vld=1,
        // acceptance needs pend_vld=0.
        if (div_valid_i && !pend_vld_q) begin
            pend_d     = (div_i == '0) ? W'(1) : div_i;
            pend_vld_d = 1'b1;
            dcnt_d     = '0;
        end

        case (st_q)
            ST_STOP:  if (en_i) st_d = ST_RUN;
            // Enable dropping exactly at period end stops right away.
            ST_RUN:   if (!en_i) st_d = prd_end ? ST_STOP : ST_DRAIN;
            ST_DRAIN: if (en_i) st_d = ST_RUN;
                      else if (prd_end) st_d = ST_STOP;
            default:  st_d = ST_STOP;
        endcase
    end

    // Outputs are registered from next-state so they line up with cnt_q.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            st_q       <= ST_STOP;
            cnt_q      <= '0;
            cur_q      <= W'(DIV_RST);
            pend_q     <= W'(DIV_RST);
            pend_vld_q <= 1'b0;
            dcnt_q     <= '0;
            clk_q      <= 1'b0;
            trg_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            st_q       <= st_d;
            cnt_q      <= cnt_d;
            cur_q      <= cur_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            dcnt_q     <= dcnt_d;
            clk_q      <= (st_d != ST_STOP) && ({1'b0, cnt_d} < hi_of(cur_d));
            trg_q      <= (st_d == ST_RUN) && (cnt_d == cur_d);
            done_q     <= (dcnt_d == DW'(DONE_DELAY));
        end
    end

    assign div_ready_o = ~pend_vld_q;
    assign div_done_o  = done_q;
    assign clk_trg_o   = trg_q;

`ifdef CLK_INT_DIV_ODD_DUTY50_EN
    // Odd N (cur even): stretch the high phase by half a source cycle.
    logic neg_q;
    always_ff @(negedge clk_i) begin
        if (!rst_n_i) neg_q <= 1'b0;
        else          neg_q <= clk_q & ~cur_q[0];
    end
    // Maps to a clock-tree OR2 cell in implementation.
    assign clk_o = clk_q | neg_q;
`else
    assign clk_o = clk_q;
`endif

endmodule

module clk_int_div_multi #(
    parameter int NUM_CH          = 4,
    parameter int DIV_VALUE_WIDTH = 16,
    parameter int DONE_DELAY      = 3,
    parameter int DIV_RST         = 1
) (
    input  logic                              clk_i,
    input  logic                              rst_n_i,
    input  logic [NUM_CH-1:0]                 en_i,
    input  logic [NUM_CH*DIV_VALUE_WIDTH-1:0] div_i,
    input  logic [NUM_CH-1:0]                 div_valid_i,
    output logic [NUM_CH-1:0]                 div_ready_o,
    output logic [NUM_CH-1:0]                 div_done_o,
    output logic [NUM_CH-1:0]                 clk_trg_o,
    output logic [NUM_CH-1:0]                 clk_o
);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        clk_int_div_ch #(
            .W          (DIV_VALUE_WIDTH),
            .DONE_DELAY (DONE_DELAY),
            .DIV_RST    (DIV_RST)
        ) u_ch (
            .clk_i       (clk_i),
            .rst_n_i     (rst_n_i),
            .en_i        (en_i[k]),
            .div_i       (div_i[k*DIV_VALUE_WIDTH +: DIV_VALUE_WIDTH]),
            .div_valid_i (div_valid_i[k]),
            .div_ready_o (div_ready_o[k]),
            .div_done_o  (div_done_o[k]),
            .clk_trg_o   (clk_trg_o[k]),
            .clk_o       (clk_o[k])
        );
    end

endmodule

// File: tb/tb_clk_int_div_multi.sv
// Directed bench for clk_int_div_multi (default build, odd-duty option off).
module tb_clk_int_div_multi;

    localparam int NCH = 4;
    localparam int W   = 16;

    logic             clk;
    logic             rst_n;
    logic [NCH-1:0]   en, dv, rdy, done, trg, clko;
    logic [NCH*W-1:0] div;

    int total = 0;
    int bad   = 0;

    clk_int_div_multi #(
        .NUM_CH          (NCH),
        .DIV_VALUE_WIDTH (W),
        .DONE_DELAY      (3),
        .DIV_RST         (1)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .en_i        (en),
        .div_i       (div),
        .div_valid_i (dv),
        .div_ready_o (rdy),
        .div_done_o  (done),
        .clk_trg_o   (trg),
        .clk_o       (clko)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic hs(input int ch, input logic [W-1:0] v);
        div[ch*W +: W] = v;
        dv[ch] = 1'b1;
        tick;
        dv[ch] = 1'b0;
        chk("hs_rdy", 32'(rdy[ch]), 32'd0);
        chk("hs_done_clr", 32'(done[ch]), 32'd0);
    endtask

    // Returns on the sample right after the apply edge (cnt=0 there).
    task automatic wait_rdy(input int ch);
        logic ok;
        int   k;
        ok = 1'b0;
        k  = 0;
        while (!ok && k < 64) begin
            tick;
            ok = rdy[ch];
            k++;
        end
        chk("rdy_wait", 32'(ok), 32'd1);
    endtask

    // Bit i of each vector = that output at sample i (sample 0 = now).
    task automatic cap(input int ch, input int n, output logic [31:0] c,
                       output logic [31:0] t, output logic [31:0] d);
        c = '0; t = '0; d = '0;
        for (int i = 0; i < n; i++) begin
            c[i] = clko[ch];
            t[i] = trg[ch];
            d[i] = done[ch];
            tick;
        end
    endtask

    logic [31:0] pc, pt, pd, pr;

    initial begin
        rst_n = 1'b0; en = '0; dv = '0; div = '0;

        // Reset state
        tick; tick;
        chk("rst_clk", 32'(clko), 32'h0);
        chk("rst_trg", 32'(trg),  32'h0);
        chk("rst_rdy", 32'(rdy),  32'hF);
        chk("rst_done", 32'(done), 32'h0);
        rst_n = 1'b1;
        tick;
        chk("stop_clk", 32'(clko), 32'h0);

        // Enable all: divide-by-2, done after 3 periods
        en = 4'hF;
        tick;
        chk("en_rise", 32'(clko), 32'hF);
        tick;
        chk("n2_low", 32'(clko), 32'h0);
        chk("n2_trg", 32'(trg),  32'hF);
        tick;
        chk("n2_high", 32'(clko), 32'hF);
        chk("n2_trg0", 32'(trg),  32'h0);
        tick; tick; tick;
        chk("done_early", 32'(done), 32'h0);
        tick;
        chk("done_set", 32'(done), 32'hF);

        // ch0 N=5
        hs(0, 16'd4);
        wait_rdy(0);
        cap(0, 16, pc, pt, pd);
        chk("n5_clk",  pc, 32'h8C63);
        chk("n5_trg",  pt, 32'h4210);
        chk("n5_done", pd, 32'h8000);

        // ch1 N=8, then update to div=2 at cnt=3
        hs(1, 16'd7);
        wait_rdy(1);
        pc = '0; pr = '0; pt = '0;
        for (int i = 0; i < 14; i++) begin
            pc[i] = clko[1];
            pr[i] = rdy[1];
            pt[i] = trg[1];
            if (i == 3) begin
                div[W +: W] = 16'd2;
                dv[1] = 1'b1;
            end
            tick;
            dv[1] = 1'b0;
        end
        chk("upd_clk", pc, 32'h090F);
        chk("upd_rdy", pr, 32'h3F0F);
        chk("upd_trg", pt, 32'h2480);

        // ch2 N=6, drop enable at cnt=1, then re-enable
        hs(2, 16'd5);
        wait_rdy(2);
        pc = '0;
        for (int i = 0; i < 10; i++) begin
            pc[i] = clko[2];
            if (i == 1) en[2] = 1'b0;
            tick;
        end
        chk("drain_clk", pc, 32'h007);
        chk("stop_hold", 32'(clko[2]), 32'd0);
        en[2] = 1'b1;
        tick;
        cap(2, 6, pc, pt, pd);
        chk("reen_clk", pc, 32'h07);

        // ch3 div=0 clamps to divide-by-2
        hs(3, 16'd0);
        wait_rdy(3);
        cap(3, 7, pc, pt, pd);
        chk("clamp_clk",  pc, 32'h55);
        chk("clamp_done", pd, 32'h40);

        // Mid-period reset on ch0 with N=10
        hs(0, 16'd9);
        wait_rdy(0);
        tick; tick; tick;
        chk("n10_hi", 32'(clko[0]), 32'd1);
        rst_n = 1'b0;
        tick;
        chk("mrst_clk",  32'(clko), 32'h0);
        chk("mrst_trg",  32'(trg),  32'h0);
        chk("mrst_rdy",  32'(rdy),  32'hF);
        chk("mrst_done", 32'(done), 32'h0);
        rst_n = 1'b1;
        tick;
        chk("mrst_rise", 32'(clko), 32'hF);
        cap(0, 4, pc, pt, pd);
        chk("mrst_n2", pc, 32'h5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
